// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared types and default widths for the split_* collector blocks
package split_pkg;

  localparam int NUM_SPLITS_DEF = 8;
  localparam int TAG_W_DEF      = 16;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } coll_state_e;

endpackage

// File: rtl/split_tag_fifo.sv
// rtl/split_tag_fifo.sv - 2-deep registered tag FIFO with flush
//   clk, rst                  clock, async active-high reset
//   flush                     empties the FIFO (contents discarded)
//   s_tvalid/s_tready/s_tdata write side
//   m_tvalid/m_tready/m_tdata read side; m_tdata reads 0 while empty
module split_tag_fifo
  import split_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [TAG_W-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [TAG_W-1:0] m_tdata
);

  logic [TAG_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign s_tready = (count_q != 2'd2);
  assign m_tvalid = (count_q != 2'd0);
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_tdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/split_verdict_collector.sv
// rtl/split_verdict_collector.sv - ANDs split verdicts, buffers accepted tags, counts results
//   clk, rst                      clock, async active-high reset
//   start, target                 begin a run (IDLE/DONE only), solutions required
//   in_valid/in_ready/in_tag/in_sat  candidate stream with per-split verdicts
//   out_valid/out_ready/out_tag   accepted-tag stream
//   accept_cnt, reject_cnt        saturating per-run statistics
//   busy, done                    run status
module split_verdict_collector
  import split_pkg::*;
#(
  parameter int NUM_SPLITS = NUM_SPLITS_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      target,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [NUM_SPLITS-1:0] in_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_W-1:0]      out_tag,
  output logic [CNT_W-1:0]      accept_cnt,
  output logic [CNT_W-1:0]      reject_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  coll_state_e      state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rej_q, rej_d;
  logic [CNT_W-1:0] acc_inc, rej_inc;
  logic             fifo_not_full;
  logic             fire;
  logic             pass;
  logic             start_ok;

  assign pass     = &in_sat;
  assign in_ready = (state_q == ST_RUN) && fifo_not_full;
  assign fire     = in_valid && in_ready;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Counters stick at all-ones instead of wrapping.
  assign acc_inc = (acc_q == '1) ? acc_q : acc_q + CNT_ONE;
  assign rej_inc = (rej_q == '1) ? rej_q : rej_q + CNT_ONE;

  split_tag_fifo #(.TAG_W(TAG_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (start_ok),
    .s_tvalid (fire && pass),
    .s_tready (fifo_not_full),
    .s_tdata  (in_tag),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .m_tdata  (out_tag)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    acc_d    = acc_q;
    rej_d    = rej_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          target_d = target;
          acc_d    = '0;
          rej_d    = '0;
          state_d  = (target == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (pass) begin
            acc_d = acc_inc;
            if (acc_inc == target_q) state_d = ST_DRAIN;
          end else begin
            rej_d = rej_inc;
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      acc_q    <= '0;
      rej_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
    end
  end

  assign accept_cnt = acc_q;
  assign reject_cnt = rej_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

  a_sat_known: assert property (@(posedge clk) disable iff (rst) fire |-> !$isunknown(in_sat));

endmodule
